pe_arr_drain: RTL and testbench

- Result-side drain for the systolic PE array.
- Snapshots the full ROWS x COLS matrix of 12-bit PE results on a capture pulse.
- Streams the snapshot out one row per beat over a valid/ready interface.
- Sits between PE_ARR outs and the downstream result sink (output buffer or file-dump bench). It is the read end to the bench/loader that drives in_w/in_a.

---
 rtl/pe_arr_drain.sv | 96 +++++++++
 tb/tb_pe_arr_drain.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pe_arr_drain.sv
// Result-side drain for the systolic PE array: snapshots the full ROWS x COLS
// result matrix on capture and streams it out one row per valid/ready beat.
module pe_arr_drain #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 12,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     capture,
  input  logic [ROWS*COLS*DW-1:0]  outs_flat,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COLS*DW-1:0]       out_data,
  output logic [RW-1:0]            out_row,
  output logic                     out_last,
  output logic                     drop,
  output logic [7:0]               drop_count
);

  localparam int            ROW_W    = COLS * DW;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]               state;
  logic [RW-1:0]            row_p0;
  logic [ROWS*COLS*DW-1:0]  snap_p0;
  logic                     xfer;
  logic                     last_row;
  logic                     reload;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign xfer     = (state == STREAM) && out_ready;
  assign last_row = (row_p0 == LAST_ROW);
  // A capture landing on the final-row transfer chains straight into the next matrix.
  assign reload   = xfer && last_row && capture;

  // Stage p0: snapshot buffer, row pointer and drop bookkeeping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      row_p0     <= '0;
      snap_p0    <= '0;
      drop       <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      drop <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            snap_p0 <= outs_flat;
            row_p0  <= '0;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (last_row) begin
              row_p0 <= '0;
              if (reload) snap_p0 <= outs_flat;
              else        state   <= IDLE;
            end else begin
              row_p0 <= row_p0 + RW'(1);
            end
          end
          if (capture && !reload) begin
            drop       <= 1'b1;
            drop_count <= sat_inc8(drop_count);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output side: muxed purely from registered state, no path from outs_flat
  always_comb begin
    out_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_p0 == RW'(r)) out_data = snap_p0[r*ROW_W +: ROW_W];
    end
  end

  assign out_valid = (state == STREAM);
  assign busy      = out_valid;
  assign out_row   = row_p0;
  assign out_last  = out_valid && last_row;

endmodule

// File: tb/tb_pe_arr_drain.sv
// Bench for pe_arr_drain: directed scenarios plus random traffic, checked
// against a queue-of-beats reference model.
module tb_pe_arr_drain;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 12;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW   = ROWS * COLS * DW;
  localparam int BW   = COLS * DW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          capture;
  logic [FW-1:0] outs_flat;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [RW-1:0] out_row;
  logic          out_last;
  logic          drop;
  logic [7:0]    drop_count;

  pe_arr_drain #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .capture(capture), .outs_flat(outs_flat),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_last(out_last),
    .drop(drop), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] data;
    int            row;
    bit            last;
  } beat_t;

  beat_t q[$];
  bit    exp_drop;
  int    exp_cnt;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // mode 0: element k = k+1; mode 1: all = val; mode 2: random
  function automatic logic [FW-1:0] mk(input int mode, input int val);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < ROWS*COLS; k++) begin
      case (mode)
        0:       f[k*DW +: DW] = DW'(k + 1);
        1:       f[k*DW +: DW] = DW'(val);
        default: f[k*DW +: DW] = DW'($urandom);
      endcase
    end
    return f;
  endfunction

  // An accepted capture becomes ROWS queued beats, lane c of row r = element r*COLS+c
  task automatic push_matrix(input logic [FW-1:0] f);
    beat_t b;
    for (int r = 0; r < ROWS; r++) begin
      b.data = '0;
      for (int c = 0; c < COLS; c++) b.data[c*DW +: DW] = f[(r*COLS + c)*DW +: DW];
      b.row  = r;
      b.last = (r == ROWS - 1);
      q.push_back(b);
    end
  endtask

  task automatic model_step(input bit cap, input logic [FW-1:0] f, input bit rdy);
    bit xfer, acc;
    xfer = (q.size() > 0) && rdy;
    acc  = cap && ((q.size() == 0) || (xfer && q.size() == 1));
    if (xfer) void'(q.pop_front());
    if (acc) push_matrix(f);
    exp_drop = cap && !acc;
    if (exp_drop && exp_cnt < 255) exp_cnt++;
  endtask

  task automatic check_outs();
    chk("out_valid", out_valid, q.size() > 0);
    chk("busy", busy, q.size() > 0);
    chk("drop", drop, exp_drop);
    chk("drop_count", drop_count, exp_cnt);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].data);
      chk("out_row", out_row, q[0].row);
      chk("out_last", out_last, q[0].last);
    end else begin
      chk("out_last_idle", out_last, 0);
    end
  endtask

  task automatic cycle(input bit cap, input logic [FW-1:0] f, input bit rdy);
    @(negedge clk);
    check_outs();
    capture   = cap;
    outs_flat = f;
    out_ready = rdy;
    model_step(cap, f, rdy);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_row"}, out_row, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_drop"}, drop, 0);
    chk({tag, "_cnt"}, drop_count, 0);
  endtask

  task automatic model_clear();
    q.delete();
    exp_drop = 1'b0;
    exp_cnt  = 0;
  endtask

  initial begin
    bit bp [7] = '{0, 0, 1, 0, 1, 1, 1};
    rstn = 1'b0; capture = 1'b0; out_ready = 1'b0; outs_flat = mk(2, 0);
    model_clear();
    #1 check_reset_state("rst");
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;

    // Basic drain
    cycle(1, mk(0, 0), 1);
    repeat (6) cycle(0, mk(2, 0), 1);

    // Backpressure; ready high on the capture cycle itself must not matter
    cycle(1, mk(0, 0), 1);
    foreach (bp[i]) cycle(0, mk(2, 0), bp[i]);
    repeat (3) cycle(0, mk(2, 0), 1);

    // Rejected capture during row1
    cycle(1, mk(0, 0), 1);
    cycle(0, mk(2, 0), 1);
    cycle(1, mk(1, 12'hFFF), 1);
    repeat (5) cycle(0, mk(2, 0), 1);

    // Back-to-back capture on the final-row transfer
    cycle(1, mk(0, 0), 1);
    repeat (3) cycle(0, mk(2, 0), 1);
    cycle(1, mk(1, 12'hABC), 1);
    repeat (6) cycle(0, mk(2, 0), 1);

    // Drop counter saturation
    cycle(1, mk(0, 0), 0);
    repeat (300) cycle(1, mk(2, 0), 0);
    repeat (6) cycle(0, mk(2, 0), 1);

    // Reset mid-stream at row2 with ready low
    cycle(1, mk(0, 0), 1);
    repeat (2) cycle(0, mk(2, 0), 1);
    cycle(0, mk(2, 0), 0);
    #2 rstn = 1'b0;
    #1 check_reset_state("midrst");
    model_clear();
    @(posedge clk);
    #2 rstn = 1'b1;
    repeat (4) cycle(0, mk(2, 0), 1);

    // Random traffic
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 5) == 0, mk(2, 0), $urandom_range(0, 3) != 0);
    repeat (8) cycle(0, mk(2, 0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
